// File: rtl/rx_arb_pkg.sv
// rx_arb_pkg
// Shared types, constants and helpers for the receiver sample arbiter.
//   arb_state_e : output sequencer states (IDLE, SEND_I, SEND_Q)
//   IQ_I / IQ_Q : encoding of the out_iq word tag
//   STAT_W      : width of the per-channel overrun counters
//   chan_w()    : width of a channel index for a given channel count
//   wrap_add()  : (a + b) mod n for operands already below n
package rx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_I = 2'd1,
        SEND_Q = 2'd2
    } arb_state_e;

    localparam logic IQ_I = 1'b0;
    localparam logic IQ_Q = 1'b1;

    localparam int STAT_W = 8;
    localparam logic [STAT_W-1:0] STAT_MAX = 8'hFF;
    localparam logic [STAT_W-1:0] STAT_ONE = 8'h01;

    // A channel index is never narrower than one bit, even for two channels.
    function automatic int chan_w(input int n);
        if (n > 2) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Both operands are below n, so one conditional subtraction suffices.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end else begin
            s = s;
        end
        return s;
    endfunction

endpackage

// File: rtl/rx_rr_picker.sv
// rx_rr_picker
// Combinational round-robin selector: returns the first pending channel at or
// after rr_ptr, searching upward and wrapping past the top channel.
//   pending     : per-channel pending bits
//   rr_ptr      : channel with highest priority this cycle
//   grant       : selected channel (only meaningful when any_pending is high)
//   any_pending : at least one channel is pending
module rx_rr_picker
    import rx_arb_pkg::*;
#(
    parameter  int NUM_RX = 4,
    localparam int CW     = chan_w(NUM_RX)
) (
    input  logic [NUM_RX-1:0] pending,
    input  logic [CW-1:0]     rr_ptr,
    output logic [CW-1:0]     grant,
    output logic              any_pending
);

    // Scan offsets from farthest to nearest so the nearest pending channel is the last writer.
    always_comb begin
        grant       = {CW{1'b0}};
        any_pending = |pending;
        for (int i = NUM_RX - 1; i >= 0; i--) begin
            if (pending[wrap_add(int'(rr_ptr), i, NUM_RX)]) begin
                grant = CW'(wrap_add(int'(rr_ptr), i, NUM_RX));
            end else begin
                grant = grant;
            end
        end
    end

endmodule

// File: rtl/rx_sample_arbiter.sv
// rx_sample_arbiter
// Captures I/Q samples from NUM_RX receiver chains into per-channel holding
// registers and serialises them round-robin as I-then-Q words on a
// valid/ready stream. A sample overwritten before it was granted sets a
// sticky per-channel overrun flag.
// Optional feature macro: RX_ARB_STATS_EN adds 8-bit saturating overrun
// counters per channel; without it overrun_count is tied to zero.
// Ports:
//   clock, rst          : single clock domain, asynchronous active-high reset
//   rx_strobe           : per-channel one-cycle sample strobe
//   rx_data_I/rx_data_Q : packed samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready : output handshake
//   out_data/out_chan/out_iq : word, its channel, and I(0)/Q(1) tag
//   overrun, overrun_clr : sticky overrun flags and their clear
//   overrun_count        : per-channel saturating overrun counts
module rx_sample_arbiter
    import rx_arb_pkg::*;
#(
    parameter  int NUM_RX     = 4,
    parameter  int DATA_WIDTH = 24,
    localparam int CW         = chan_w(NUM_RX)
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic [NUM_RX-1:0]            rx_strobe,
    input  logic [NUM_RX*DATA_WIDTH-1:0] rx_data_I,
    input  logic [NUM_RX*DATA_WIDTH-1:0] rx_data_Q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CW-1:0]                out_chan,
    output logic                         out_iq,
    output logic [NUM_RX-1:0]            overrun,
    input  logic                         overrun_clr,
    output logic [NUM_RX*STAT_W-1:0]     overrun_count
);

    logic [DATA_WIDTH-1:0] hold_i_r [NUM_RX];
    logic [DATA_WIDTH-1:0] hold_q_r [NUM_RX];
    logic [NUM_RX-1:0]     pending_r;
    logic [CW-1:0]         rr_ptr_r;
    logic [DATA_WIDTH-1:0] out_q_r;
    arb_state_e            state_r;
    arb_state_e            state_s;

    logic [CW-1:0]         pick_ptr_s;
    logic [CW-1:0]         chan_inc_s;
    logic [CW-1:0]         grant_s;
    logic                  any_pending_s;
    logic                  grant_fire_s;
    logic [NUM_RX-1:0]     granted_s;
    logic [NUM_RX-1:0]     overrun_evt_s;

    rx_rr_picker #(
        .NUM_RX (NUM_RX)
    ) u_picker (
        .pending     (pending_r),
        .rr_ptr      (pick_ptr_s),
        .grant       (grant_s),
        .any_pending (any_pending_s)
    );

    // Channel after the one currently on the output, wrapping at NUM_RX.
    always_comb begin
        if (out_chan == CW'(NUM_RX - 1)) begin
            chan_inc_s = {CW{1'b0}};
        end else begin
            chan_inc_s = out_chan + CW'(1);
        end
    end

    // Back-to-back grant out of SEND_Q must already see the advanced pointer.
    always_comb begin
        if (state_r == SEND_Q) begin
            pick_ptr_s = chan_inc_s;
        end else begin
            pick_ptr_s = rr_ptr_r;
        end
    end

    // Sequencer next-state and grant decision.
    always_comb begin
        state_s      = state_r;
        grant_fire_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_pending_s) begin
                    state_s      = SEND_I;
                    grant_fire_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND_I: begin
                if (out_ready) begin
                    state_s = SEND_Q;
                end else begin
                    state_s = SEND_I;
                end
            end
            SEND_Q: begin
                if (out_ready && any_pending_s) begin
                    state_s      = SEND_I;
                    grant_fire_s = 1'b1;
                end else if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = SEND_Q;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // A strobe on a channel being granted this cycle is a refill, not an overrun.
    always_comb begin
        granted_s     = {NUM_RX{1'b0}};
        overrun_evt_s = {NUM_RX{1'b0}};
        for (int k = 0; k < NUM_RX; k++) begin
            granted_s[k]     = grant_fire_s && (grant_s == CW'(k));
            overrun_evt_s[k] = rx_strobe[k] && pending_r[k] && !granted_s[k];
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Round-robin pointer advances past a channel once its Q word is taken.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= {CW{1'b0}};
        end else if ((state_r == SEND_Q) && out_ready) begin
            rr_ptr_r <= chan_inc_s;
        end
    end

    // Holding registers, pending bits and sticky overrun flags.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pending_r <= {NUM_RX{1'b0}};
            overrun   <= {NUM_RX{1'b0}};
            for (int k = 0; k < NUM_RX; k++) begin
                hold_i_r[k] <= {DATA_WIDTH{1'b0}};
                hold_q_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUM_RX; k++) begin
                if (rx_strobe[k]) begin
                    pending_r[k] <= 1'b1;
                    hold_i_r[k]  <= rx_data_I[k*DATA_WIDTH +: DATA_WIDTH];
                    hold_q_r[k]  <= rx_data_Q[k*DATA_WIDTH +: DATA_WIDTH];
                end else if (granted_s[k]) begin
                    pending_r[k] <= 1'b0;
                end
                if (overrun_evt_s[k]) begin
                    overrun[k] <= 1'b1;
                end else if (overrun_clr) begin
                    overrun[k] <= 1'b0;
                end
            end
        end
    end

    // Output word registers; the Q word is parked in out_q_r until I is taken.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_iq    <= IQ_I;
            out_chan  <= {CW{1'b0}};
            out_data  <= {DATA_WIDTH{1'b0}};
            out_q_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            out_valid <= (state_s != IDLE);
            out_iq    <= (state_s == SEND_Q) ? IQ_Q : IQ_I;
            if (grant_fire_s) begin
                out_chan <= grant_s;
                out_data <= hold_i_r[grant_s];
                out_q_r  <= hold_q_r[grant_s];
            end else if ((state_r == SEND_I) && out_ready) begin
                out_data <= out_q_r;
            end
        end
    end

`ifdef RX_ARB_STATS_EN
    logic [STAT_W-1:0] ovr_cnt_r [NUM_RX];

    // Saturating overrun counters; an event coinciding with a clear counts as one.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_RX; k++) begin
                ovr_cnt_r[k] <= {STAT_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUM_RX; k++) begin
                if (overrun_evt_s[k] && overrun_clr) begin
                    ovr_cnt_r[k] <= STAT_ONE;
                end else if (overrun_evt_s[k] && (ovr_cnt_r[k] != STAT_MAX)) begin
                    ovr_cnt_r[k] <= ovr_cnt_r[k] + STAT_ONE;
                end else if (overrun_clr) begin
                    ovr_cnt_r[k] <= {STAT_W{1'b0}};
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RX; g++) begin : g_cnt_pack
        assign overrun_count[g*STAT_W +: STAT_W] = ovr_cnt_r[g];
    end
`else
    assign overrun_count = {(NUM_RX*STAT_W){1'b0}};
`endif

endmodule

// File: tb/tb_rx_sample_arbiter.sv
// tb_rx_sample_arbiter
// Randomised and directed stimulus against a transaction-level reference
// model. The model keeps per-channel latest samples, a words-in-flight count
// and a round-robin pointer; whenever the output path is free after an edge
// it grants the next pending channel and queues that channel's I and Q words.
// A separate negedge monitor compares every presented word with the queue.
module tb_rx_sample_arbiter;

    localparam int NUM_RX = 4;
    localparam int DW     = 24;
    localparam int CW     = 2;

    logic                 clock;
    logic                 rst;
    logic [NUM_RX-1:0]    rx_strobe;
    logic [NUM_RX*DW-1:0] rx_data_I;
    logic [NUM_RX*DW-1:0] rx_data_Q;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [CW-1:0]        out_chan;
    logic                 out_iq;
    logic [NUM_RX-1:0]    overrun;
    logic                 overrun_clr;
    logic [NUM_RX*8-1:0]  overrun_count;

    rx_sample_arbiter #(.NUM_RX(NUM_RX), .DATA_WIDTH(DW)) dut (
        .clock         (clock),
        .rst           (rst),
        .rx_strobe     (rx_strobe),
        .rx_data_I     (rx_data_I),
        .rx_data_Q     (rx_data_Q),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_chan      (out_chan),
        .out_iq        (out_iq),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
        .overrun_count (overrun_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          chan;
        int          iq;
        logic [DW-1:0] data;
    } word_t;

    word_t         exp_q[$];
    int            m_pend [NUM_RX];
    logic [DW-1:0] m_hi   [NUM_RX];
    logic [DW-1:0] m_hq   [NUM_RX];
    int            m_ovr  [NUM_RX];
    int            m_cnt  [NUM_RX];
    int            m_ptr;
    int            m_left;
    int            m_cur;

    int checks;
    int errors;

    initial begin
        checks = 0;
        errors = 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, advanced on every clock edge (or reset).
    initial forever begin
        int acc;
        int g;
        int c;
        int ev;
        @(posedge clock or posedge rst);
        if (rst) begin
            exp_q.delete();
            m_ptr  = 0;
            m_left = 0;
            m_cur  = 0;
            for (int k = 0; k < NUM_RX; k++) begin
                m_pend[k] = 0;
                m_ovr[k]  = 0;
                m_cnt[k]  = 0;
                m_hi[k]   = '0;
                m_hq[k]   = '0;
            end
        end else begin
            acc = (m_left > 0 && out_ready) ? 1 : 0;
            if (acc == 1 && m_left == 1) m_ptr = (m_cur + 1) % NUM_RX;
            m_left = m_left - acc;
            g = -1;
            if (m_left == 0) begin
                for (int i = 0; i < NUM_RX; i++) begin
                    c = (m_ptr + i) % NUM_RX;
                    if (m_pend[c] != 0 && g < 0) g = c;
                end
            end
            if (g >= 0) begin
                exp_q.push_back('{chan: g, iq: 0, data: m_hi[g]});
                exp_q.push_back('{chan: g, iq: 1, data: m_hq[g]});
                m_left    = 2;
                m_cur     = g;
                m_pend[g] = 0;
            end
            for (int k = 0; k < NUM_RX; k++) begin
                ev = (rx_strobe[k] && m_pend[k] != 0) ? 1 : 0;
                if (rx_strobe[k]) begin
                    m_pend[k] = 1;
                    m_hi[k]   = rx_data_I[k*DW +: DW];
                    m_hq[k]   = rx_data_Q[k*DW +: DW];
                end
                if (ev == 1) m_ovr[k] = 1;
                else if (overrun_clr) m_ovr[k] = 0;
                if (ev == 1 && overrun_clr) m_cnt[k] = 1;
                else if (ev == 1) m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
                else if (overrun_clr) m_cnt[k] = 0;
            end
        end
    end

    // Monitor: compares the presented word, handshake state and overrun status.
    initial forever begin
        int exp_cnt;
        @(negedge clock);
        if (!rst) begin
            check("valid", 32'(out_valid), 32'(m_left > 0));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(out_chan), 32'hFFFF_FFFF);
                end else begin
                    check("chan", 32'(out_chan), 32'(exp_q[0].chan));
                    check("iq",   32'(out_iq),   32'(exp_q[0].iq));
                    check("data", 32'(out_data), 32'(exp_q[0].data));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            for (int k = 0; k < NUM_RX; k++) begin
`ifdef RX_ARB_STATS_EN
                exp_cnt = m_cnt[k];
`else
                exp_cnt = 0;
`endif
                check("overrun", 32'(overrun[k]), 32'(m_ovr[k]));
                check("overrun_count", 32'(overrun_count[k*8 +: 8]), 32'(exp_cnt));
            end
        end
    end

    task automatic randomize_data(input logic [NUM_RX-1:0] stb);
        for (int k = 0; k < NUM_RX; k++) begin
            if (stb[k]) begin
                rx_data_I[k*DW +: DW] = 24'($urandom);
                rx_data_Q[k*DW +: DW] = 24'($urandom);
            end
        end
    endtask

    // Present inputs for one edge, then return 1 time unit after that edge.
    task automatic step(input logic [NUM_RX-1:0] stb, input logic rdy, input logic clr);
        rx_strobe   = stb;
        out_ready   = rdy;
        overrun_clr = clr;
        @(posedge clock);
        #1;
        rx_strobe   = '0;
        overrun_clr = 1'b0;
    endtask

    task automatic rstep(input logic [NUM_RX-1:0] stb, input logic rdy, input logic clr);
        randomize_data(stb);
        step(stb, rdy, clr);
    endtask

    initial begin
        logic [NUM_RX-1:0] stb;
        logic              rdy;
        logic              clr;

        rst         = 1'b1;
        rx_strobe   = '0;
        rx_data_I   = '0;
        rx_data_Q   = '0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_chan",  32'(out_chan),  32'd0);
        check("rst_iq",    32'(out_iq),    32'd0);
        check("rst_ovr",   32'(overrun),   32'd0);
        check("rst_cnt",   32'(overrun_count), 32'd0);
        rst = 1'b0;

        // Single sample on channel 2.
        rx_data_I[2*DW +: DW] = 24'h000123;
        rx_data_Q[2*DW +: DW] = 24'hFFFEDC;
        step(4'b0100, 1'b1, 1'b0);
        repeat (6) step(4'b0000, 1'b1, 1'b0);

        // All channels at once, then a pair probing where the pointer landed.
        rstep(4'b1111, 1'b1, 1'b0);
        repeat (12) step(4'b0000, 1'b1, 1'b0);
        rstep(4'b1001, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b1, 1'b0);

        // Back-pressure during SEND_I with two samples landing on channel 1.
        rstep(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 3 || i == 8) rstep(4'b0010, 1'b0, 1'b0);
            else step(4'b0000, 1'b0, 1'b0);
        end
        repeat (10) step(4'b0000, 1'b1, 1'b0);

        // Refill of channel 0 on the very cycle it is granted.
        step(4'b0000, 1'b1, 1'b1);
        rstep(4'b0001, 1'b1, 1'b0);
        rstep(4'b0001, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b1, 1'b0);

        // Many overruns on channel 3 while stalled, then clear and drain.
        for (int i = 0; i < 310; i++) rstep(4'b1000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        repeat (6) step(4'b0000, 1'b1, 1'b0);

        // Clear coinciding with a fresh overrun keeps the flag.
        rstep(4'b0100, 1'b0, 1'b0);
        rstep(4'b0100, 1'b0, 1'b0);
        rstep(4'b0100, 1'b0, 1'b1);
        repeat (6) step(4'b0000, 1'b1, 1'b0);

        // Randomised traffic with random back-pressure and occasional clears.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NUM_RX; k++) stb[k] = ($urandom_range(0, 99) < 15);
            rdy = ($urandom_range(0, 99) < 70);
            clr = ($urandom_range(0, 99) < 3);
            rstep(stb, rdy, clr);
        end
        repeat (20) step(4'b0000, 1'b1, 1'b0);
        check("drained_valid", 32'(out_valid), 32'd0);

        // Reset asserted in the middle of SEND_Q.
        rstep(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        out_ready = 1'b0;
        check("sendq_valid", 32'(out_valid), 32'd1);
        check("sendq_iq", 32'(out_iq), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data",  32'(out_data),  32'd0);
        @(posedge clock);
        #1;
        rst = 1'b0;
        repeat (6) step(4'b0000, 1'b1, 1'b0);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        rstep(4'b0010, 1'b1, 1'b0);
        repeat (6) step(4'b0000, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
